// File: rtl/mac_acc_ctrl_pkg.sv
// Shared widths, cfg bit positions and FSM encoding for the accumulator job sequencer.
package mac_acc_ctrl_pkg;

  localparam int unsigned MAC_MIN_WIDTH  = 8;
  localparam int unsigned MAC_ACC_WIDTH  = 4 * MAC_MIN_WIDTH;
  localparam int unsigned MAC_CONF_WIDTH = 3;
  localparam int unsigned LEN_WIDTH      = 16;
  localparam int unsigned LANES          = 4;
  localparam int unsigned DATA_WIDTH     = LANES * MAC_ACC_WIDTH;

  localparam int unsigned ACC_EN_BIT  = 2;
  localparam logic [1:0]  MODE_SINGLE = 2'b00;
  localparam logic [1:0]  MODE_QUAD   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_CAP  = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  typedef logic [MAC_CONF_WIDTH-1:0] cfg_t;
  typedef logic [LEN_WIDTH-1:0]      len_t;
  typedef logic [DATA_WIDTH-1:0]     data_t;

  function automatic logic cfg_acc(input cfg_t cfg);
    return cfg[ACC_EN_BIT];
  endfunction

endpackage

// File: rtl/mac_acc_ctrl.sv
// Job sequencer for a 4-lane accumulator: loads cfg/init, gates accumulate per beat,
// captures the 128-bit result and holds it until the consumer takes it.
module mac_acc_ctrl
  import mac_acc_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [MAC_CONF_WIDTH-1:0] cmd_cfg,
  input  logic [LEN_WIDTH-1:0]      cmd_len,
  input  logic [DATA_WIDTH-1:0]     cmd_init,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      mac_en,
  output logic                      mac_cset,
  output logic [MAC_CONF_WIDTH-1:0] mac_cfg,
  output logic [DATA_WIDTH-1:0]     mac_init,
  output logic [DATA_WIDTH-1:0]     mac_in,
  input  logic [DATA_WIDTH-1:0]     mac_out,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [DATA_WIDTH-1:0]     res_data,
  output logic                      busy
);

  state_t state;
  len_t   cnt;
  logic   cmd_fire;
  logic   in_fire;
  logic   res_fire;
  logic   acc_mode;

  assign cmd_fire = cmd_valid & cmd_ready;
  assign in_fire  = in_valid & in_ready;
  assign res_fire = res_valid & res_ready;
  assign acc_mode = cfg_acc(mac_cfg);

  // Enable must track the accepted beat in the same cycle; the product stream passes straight through.
  assign mac_en = in_fire & acc_mode;
  assign mac_in = in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mac_cfg   <= '0;
      mac_init  <= '0;
      cmd_ready <= 1'b0;
      in_ready  <= 1'b0;
      mac_cset  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_fire) begin
            mac_cfg   <= cmd_cfg;
            mac_init  <= cmd_init;
            cnt       <= cmd_len;
            cmd_ready <= 1'b0;
            mac_cset  <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          mac_cset <= 1'b0;
          if (acc_mode && (cnt == '0)) begin
            state <= ST_CAP;
          end else begin
            in_ready <= 1'b1;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (in_fire) begin
            if (cnt != '0) cnt <= cnt - LEN_WIDTH'(1);
            // Mult-only jobs take exactly one beat regardless of length.
            if (!acc_mode || (cnt == LEN_WIDTH'(1))) begin
              in_ready <= 1'b0;
              state    <= ST_CAP;
            end
          end
        end
        ST_CAP: begin
          res_data  <= mac_out;
          res_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (res_fire) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_acc_ctrl.sv
// Table-driven bench for mac_acc_ctrl with a behavioural accumulator block and a result scoreboard.
module tb_mac_acc_ctrl;
  import mac_acc_ctrl_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [2:0]    cmd_cfg;
  logic [15:0]   cmd_len;
  logic [127:0]  cmd_init;
  logic          in_valid, in_ready;
  logic [127:0]  in_data;
  logic          mac_en, mac_cset;
  logic [2:0]    mac_cfg;
  logic [127:0]  mac_init, mac_in, mac_out;
  logic          res_valid, res_ready;
  logic [127:0]  res_data;
  logic          busy;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  logic [127:0] sb[$];

  mac_acc_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_cfg(cmd_cfg),
    .cmd_len(cmd_len), .cmd_init(cmd_init),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mac_en(mac_en), .mac_cset(mac_cset), .mac_cfg(mac_cfg),
    .mac_init(mac_init), .mac_in(mac_in), .mac_out(mac_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural accumulator block: single = 4x32, dual = 2x64, quad = 1x128.
  function automatic logic [127:0] lane_add(input logic [2:0] cfg, input logic [127:0] a,
                                            input logic [127:0] b);
    logic [127:0] r;
    r = '0;
    case (cfg[1:0])
      2'b00:   for (int k = 0; k < 4; k++) r[k*32 +: 32] = a[k*32 +: 32] + b[k*32 +: 32];
      2'b10:   r = a + b;
      default: begin
        r[63:0]   = a[63:0] + b[63:0];
        r[127:64] = a[127:64] + b[127:64];
      end
    endcase
    return r;
  endfunction

  logic [127:0] acc_r, pipe_r;
  logic [2:0]   mcfg_r;
  always @(posedge clk) begin
    if (rst) begin
      acc_r <= '0; pipe_r <= '0; mcfg_r <= '0;
    end else begin
      pipe_r <= mac_in;
      if (mac_cset) begin
        acc_r  <= mac_init;
        mcfg_r <= mac_cfg;
      end else if (mac_en) begin
        acc_r <= lane_add(mcfg_r, acc_r, mac_in);
      end
    end
  end
  assign mac_out = mcfg_r[2] ? acc_r : pipe_r;

  typedef struct packed {
    logic [2:0]        cfg;
    logic [15:0]       len;
    logic [127:0]      init;
    logic [3:0][127:0] beats;
    logic [2:0]        nb;
    logic [2:0]        nacc;
    logic              bubble;
    logic [3:0]        hold;
    logic [127:0]      exp;
  } vec_t;

  function automatic logic [127:0] lanes(input logic [31:0] l3, l2, l1, l0);
    return {l3, l2, l1, l0};
  endfunction

  function automatic vec_t mk(input logic [2:0] cfg, input logic [15:0] len,
                              input logic [127:0] init, b0, b1, b2,
                              input logic [2:0] nb, nacc, input logic bubble,
                              input logic [3:0] hold, input logic [127:0] exp);
    vec_t v;
    v.cfg = cfg; v.len = len; v.init = init;
    v.beats[0] = b0; v.beats[1] = b1; v.beats[2] = b2; v.beats[3] = '0;
    v.nb = nb; v.nacc = nacc; v.bubble = bubble; v.hold = hold; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents the command and returns the cycle it was accepted in; call just after a negedge.
  task automatic send_cmd(input vec_t v, output int t_fire, output bit ok);
    int guard = 0;
    cmd_cfg = v.cfg; cmd_len = v.len; cmd_init = v.init; cmd_valid = 1'b1;
    #1;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk); #1; guard++;
    end
    ok = cmd_ready;
    t_fire = cyc;
    if (!ok) begin
      chk("cmd_ready_timeout", 128'(cmd_ready), 128'(1));
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("cset_after_fire", 128'(mac_cset), 128'(1));
    chk("cmd_ready_load", 128'(cmd_ready), 128'(0));
    chk("mac_cfg_held", 128'(mac_cfg), 128'(v.cfg));
    chk("mac_init_held", mac_init, v.init);
  endtask

  task automatic run_job(input vec_t v);
    int t_fire, t_last, nacc, i, guard, exp_cyc;
    bit ok, seen_ir;
    logic [127:0] exp;
    sb.push_back(v.exp);
    send_cmd(v, t_fire, ok);
    if (!ok) begin
      void'(sb.pop_front());
      return;
    end
    i = 0; nacc = 0; t_last = 0; seen_ir = 1'b0; guard = 0;
    while (guard < 200) begin
      if (i < int'(v.nb) && (!v.bubble || (cyc % 3 == 0))) begin
        in_valid = 1'b1; in_data = v.beats[i];
      end else begin
        in_valid = 1'b0; in_data = 128'($urandom);
      end
      #1;
      if (in_ready) seen_ir = 1'b1;
      if (in_valid && in_ready) begin
        if (nacc == 0) chk("mac_en_on_beat", 128'(mac_en), 128'(v.cfg[2]));
        nacc++; i++; t_last = cyc;
      end
      if (res_valid) break;
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    if (!res_valid) begin
      chk("res_valid_timeout", 128'(res_valid), 128'(1));
      void'(sb.pop_front());
      return;
    end
    chk("beats_accepted", 128'(nacc), 128'(v.nacc));
    exp_cyc = (v.nacc == 0) ? t_fire + 3 : t_last + 2;
    chk("result_latency", 128'(cyc), 128'(exp_cyc));
    if (v.nacc == 0) chk("in_ready_never", 128'(seen_ir), 128'(0));
    for (int k = 0; k < int'(v.hold); k++) begin
      @(negedge clk); #1;
      chk("hold_res_data", res_data, sb[0]);
      chk("hold_res_valid", 128'(res_valid), 128'(1));
      chk("hold_cmd_ready", 128'(cmd_ready), 128'(0));
      chk("hold_mac_en", 128'(mac_en), 128'(0));
    end
    exp = sb.pop_front();
    chk("res_data", res_data, exp);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    chk("res_valid_drop", 128'(res_valid), 128'(0));
    chk("busy_idle", 128'(busy), 128'(0));
    chk("cmd_ready_idle", 128'(cmd_ready), 128'(1));
  endtask

  vec_t vecs[8];

  initial begin
    int t_fire, nacc, guard;
    bit ok;
    vec_t vr;

    vecs[0] = mk(3'b100, 16'd3, '0, lanes(0, 0, 0, 1), lanes(0, 0, 0, 2), lanes(0, 0, 0, 3),
                 3'd3, 3'd3, 1'b0, 4'd0, lanes(0, 0, 0, 6));
    vecs[1] = mk(3'b110, 16'd1, lanes(0, 0, 0, 32'hFFFFFFFF), lanes(0, 0, 0, 1), '0, '0,
                 3'd1, 3'd1, 1'b0, 4'd0, lanes(0, 0, 1, 0));
    vecs[2] = mk(3'b100, 16'd1, lanes(0, 0, 0, 32'hFFFFFFFF), lanes(0, 0, 0, 1), '0, '0,
                 3'd1, 3'd1, 1'b0, 4'd0, lanes(0, 0, 0, 0));
    vecs[3] = mk(3'b000, 16'd5, lanes(9, 9, 9, 9), lanes(4, 3, 2, 1), lanes(7, 7, 7, 7), '0,
                 3'd2, 3'd1, 1'b0, 4'd0, lanes(4, 3, 2, 1));
    vecs[4] = mk(3'b100, 16'd0, lanes(8, 7, 6, 5), lanes(1, 1, 1, 1), '0, '0,
                 3'd1, 3'd0, 1'b0, 4'd0, lanes(8, 7, 6, 5));
    vecs[5] = mk(3'b101, 16'd1, lanes(0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF), lanes(0, 5, 0, 1), '0, '0,
                 3'd1, 3'd1, 1'b0, 4'd0, lanes(0, 5, 0, 0));
    vecs[6] = mk(3'b100, 16'd3, lanes(0, 0, 100, 0), lanes(1, 0, 0, 10), lanes(2, 0, 0, 20),
                 lanes(3, 0, 0, 30), 3'd3, 3'd3, 1'b1, 4'd10, lanes(6, 0, 100, 60));
    vecs[7] = mk(3'b111, 16'd2, lanes(0, 32'hFFFFFFFF, 0, 0), lanes(0, 1, 0, 0), lanes(0, 0, 0, 3), '0,
                 3'd2, 3'd2, 1'b0, 4'd0, lanes(1, 0, 0, 3));

    rst = 1'b1; cmd_valid = 1'b0; cmd_cfg = '0; cmd_len = '0; cmd_init = '0;
    in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cmd_ready", 128'(cmd_ready), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_res_valid", 128'(res_valid), 128'(0));
    chk("rst_res_data", res_data, '0);
    chk("rst_mac_cfg", 128'(mac_cfg), 128'(0));
    chk("rst_mac_cset", 128'(mac_cset), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[n]) begin
      @(negedge clk);
      run_job(vecs[n]);
    end

    // Reset in RUN after 2 of 4 beats: partial job discarded, fresh job still correct.
    @(negedge clk);
    vr = mk(3'b100, 16'd4, '0, '0, '0, '0, 3'd0, 3'd0, 1'b0, 4'd0, '0);
    send_cmd(vr, t_fire, ok);
    nacc = 0; guard = 0;
    in_valid = 1'b1; in_data = lanes(0, 0, 0, 5);
    while (nacc < 2 && guard < 50) begin
      #1;
      if (in_ready) nacc++;
      @(negedge clk);
      guard++;
    end
    chk("rst_seq_beats", 128'(nacc), 128'(2));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(0));
    chk("midrst_mac_en", 128'(mac_en), 128'(0));
    chk("midrst_res_valid", 128'(res_valid), 128'(0));
    in_valid = 1'b0;
    @(negedge clk);
    run_job(mk(3'b100, 16'd1, '0, lanes(0, 0, 0, 9), '0, '0, 3'd1, 3'd1, 1'b0, 4'd0,
               lanes(0, 0, 0, 9)));

    chk("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
